// File: rtl/ram_stream_reader.sv
// Streaming port-B read sequencer: issues sequential RAM reads and buffers the returned words
// into a small FIFO that feeds a valid/ready stream. RAM_READER_LOOP_EN enables looping + stop.
module ram_stream_reader #(
  parameter int unsigned ADDR_SIZE  = 16,
  parameter int unsigned DATA_SIZE  = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 start,
  input  logic [ADDR_SIZE-1:0] base_addr,
  input  logic [ADDR_SIZE:0]   length,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_SIZE-1:0] addr_B,
  output logic                 r_e_B,
  input  logic [DATA_SIZE-1:0] data_out_B,
  output logic [DATA_SIZE-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready
`ifdef RAM_READER_LOOP_EN
  ,
  input  logic                 stop
`endif
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] Depth = (CntW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic loop_en;
  logic stop_req;

`ifdef RAM_READER_LOOP_EN
  assign loop_en  = 1'b1;
  assign stop_req = stop;
`else
  assign loop_en  = 1'b0;
  assign stop_req = 1'b0;
`endif

  logic [1:0]           state_q, state_d;
  logic [ADDR_SIZE-1:0] base_q, base_d;
  logic [ADDR_SIZE-1:0] cur_q, cur_d;
  logic [ADDR_SIZE:0]   len_q, len_d;
  logic [ADDR_SIZE:0]   issued_q, issued_d;
  logic                 done_q, done_d;
  logic                 inflight_q;

  logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q;

  logic                 push;
  logic                 pop;
  logic                 credit;
  logic                 issue;
  logic                 last_issue;
  logic [CntW:0]        occupancy;

  assign push = inflight_q;
  assign pop  = (count_q != '0) && m_ready;

  // Occupancy after this edge if we issue now: the word in flight lands next cycle.
  assign occupancy = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q} - {{CntW{1'b0}}, pop};
  assign credit    = occupancy < Depth;

  assign issue      = (state_q == StRun) && credit && !stop_req;
  assign last_issue = (issued_q + (ADDR_SIZE + 1)'(1)) == len_q;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    cur_d    = cur_q;
    issued_d = issued_q;
    done_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (length != '0) begin
            base_d   = base_addr;
            len_d    = length;
            cur_d    = base_addr;
            issued_d = '0;
            state_d  = StRun;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      StRun: begin
        if (stop_req) begin
          state_d = StDrain;
        end else if (issue) begin
          if (last_issue && loop_en) begin
            // Reload in the same cycle so the next read follows without a bubble.
            cur_d    = base_q;
            issued_d = '0;
          end else begin
            cur_d    = cur_q + ADDR_SIZE'(1);
            issued_d = issued_q + (ADDR_SIZE + 1)'(1);
            if (last_issue) begin
              state_d = StDrain;
            end
          end
        end
      end

      StDrain: begin
        if ((count_q == '0) && !inflight_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= StIdle;
      base_q     <= '0;
      len_q      <= '0;
      cur_q      <= '0;
      issued_q   <= '0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      cur_q      <= cur_d;
      issued_q   <= issued_d;
      done_q     <= done_d;
      inflight_q <= issue;
    end
  end

  // Output FIFO; credit gating guarantees a push never meets a full buffer.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= data_out_B;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign busy    = state_q != StIdle;
  assign done    = done_q;
  assign r_e_B   = issue;
  assign addr_B  = cur_q;
  assign m_valid = count_q != '0;
  assign m_data  = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader: RAM model, address/data scoreboard queues filled
// from the stimulus, and immediate assertions at every comparison point.
module tb_ram_stream_reader;

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic [15:0] base_addr;
  logic [16:0] length;
  logic        busy;
  logic        done;
  logic [15:0] addr_B;
  logic        r_e_B;
  logic [31:0] data_out_B;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        stop;

  ram_stream_reader #(
    .ADDR_SIZE (16),
    .DATA_SIZE (32),
    .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .addr_B    (addr_B),
    .r_e_B     (r_e_B),
    .data_out_B(data_out_B),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready)
`ifdef RAM_READER_LOOP_EN
    ,
    .stop      (stop)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [15:0] a);
    return {a ^ 16'hC35A, a};
  endfunction

  // RAM port B: registered read, data valid the cycle after r_e_B.
  always_ff @(posedge clk) begin
    if (r_e_B) data_out_B <= data_of(addr_B);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  logic [15:0] addr_q[$];
  logic [31:0] data_q[$];
  int          cyc = 0;
  int          done_cnt = 0, word_cnt = 0, issue_cnt = 0, max_cnt = 0;
  int          first_cyc = 0, last_cyc = 0, s_cyc = 0, d0 = 0, w0 = 0, i0 = 0;
  bit          first_seen = 1'b0, busy_seen = 1'b0;
  logic        prev_v = 1'b0, prev_r = 1'b0;
  logic [31:0] prev_d = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (nrst) begin
      if (r_e_B) begin
        issue_cnt++;
        if (addr_q.size() == 0) check("addr_extra", 64'(addr_q.size()), 64'(1));
        else check("addr_B", 64'(addr_B), 64'(addr_q.pop_front()));
      end
      if (m_valid && !first_seen) begin
        first_seen = 1'b1;
        first_cyc  = cyc;
      end
      if (prev_v && !prev_r && m_valid) check("m_data_hold", 64'(m_data), 64'(prev_d));
      if (m_valid && m_ready) begin
        word_cnt++;
        last_cyc = cyc;
        if (data_q.size() == 0) check("data_extra", 64'(data_q.size()), 64'(1));
        else check("m_data", 64'(m_data), 64'(data_q.pop_front()));
      end
      if (done) done_cnt++;
      if (busy) busy_seen = 1'b1;
      if (int'(dut.count_q) > max_cnt) max_cnt = int'(dut.count_q);
      prev_v = m_valid;
      prev_r = m_ready;
      prev_d = m_data;
    end else begin
      prev_v = 1'b0;
      prev_r = 1'b0;
    end
  end

  task automatic kick(input logic [15:0] b, input int l, input bit push_exp);
    if (push_exp) begin
      for (int i = 0; i < l; i++) begin
        addr_q.push_back(b + 16'(i));
        data_q.push_back(data_of(b + 16'(i)));
      end
    end
    d0         = done_cnt;
    w0         = word_cnt;
    i0         = issue_cnt;
    first_seen = 1'b0;
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = b;
    length    = 17'(l);
    @(posedge clk);
    #1;
    start = 1'b0;
    s_cyc = cyc;
  endtask

  task automatic finish_xfer(input string tag, input int words);
    for (int c = 0; c < 300 && done_cnt == d0; c++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_once"}, 64'(done_cnt - d0), 64'(1));
    check({tag, "_busy_low"}, 64'(busy), 64'(0));
    check({tag, "_words"}, 64'(word_cnt - w0), 64'(words));
    check({tag, "_data_left"}, 64'(data_q.size()), 64'(0));
    check({tag, "_addr_left"}, 64'(addr_q.size()), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst      = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    m_ready   = 1'b1;
    stop      = 1'b0;
    #12;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_re", 64'(r_e_B), 64'(0));
    check("rst_addr", 64'(addr_B), 64'(0));
    check("rst_valid", 64'(m_valid), 64'(0));
    check("rst_mdata", 64'(m_data), 64'(0));
    @(negedge clk);
    nrst = 1'b1;

    // 1: basic 8-word transfer, full rate.
    kick(16'h0010, 8, 1'b1);
    finish_xfer("t1", 8);
    check("t1_latency", 64'(first_cyc - s_cyc), 64'(2));
    check("t1_rate", 64'(last_cyc - first_cyc), 64'(7));

    // 2: back-pressure toggling every clock; a start mid-transfer must be ignored.
    max_cnt = 0;
    kick(16'h0100, 16, 1'b1);
    for (int c = 0; c < 300 && done_cnt == d0; c++) begin
      @(posedge clk);
      #1;
      m_ready = ~m_ready;
      if (c == 4) begin
        start     = 1'b1;
        base_addr = 16'h0999;
        length    = 17'd5;
      end
      if (c == 5) start = 1'b0;
    end
    m_ready = 1'b1;
    finish_xfer("t2", 16);
    check("t2_fifo_max_ok", 64'(max_cnt <= 4), 64'(1));

    // 3: address wrap.
    kick(16'hFFFE, 4, 1'b1);
    finish_xfer("t3", 4);

    // 4: zero-length request.
    busy_seen = 1'b0;
    kick(16'h0050, 0, 1'b1);
    check("t4_done_now", 64'(done), 64'(1));
    check("t4_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
    check("t4_done_clear", 64'(done), 64'(0));
    check("t4_no_issue", 64'(issue_cnt - i0), 64'(0));
    check("t4_busy_never", 64'(busy_seen), 64'(0));

    // 5: reset after 3 of 10 words, then a fresh short transfer.
    kick(16'h0040, 10, 1'b1);
    for (int c = 0; c < 60 && (word_cnt - w0) < 3; c++) @(negedge clk);
    @(posedge clk);
    #2;
    nrst = 1'b0;
    #1;
    check("t5_busy", 64'(busy), 64'(0));
    check("t5_done", 64'(done), 64'(0));
    check("t5_re", 64'(r_e_B), 64'(0));
    check("t5_addr", 64'(addr_B), 64'(0));
    check("t5_valid", 64'(m_valid), 64'(0));
    check("t5_mdata", 64'(m_data), 64'(0));
    addr_q.delete();
    data_q.delete();
    @(negedge clk);
    nrst = 1'b1;
    kick(16'h0000, 2, 1'b1);
    finish_xfer("t5b", 2);

`ifdef RAM_READER_LOOP_EN
    // 6: looping over 3 words, stopped after 7 issues.
    for (int i = 0; i < 7; i++) begin
      addr_q.push_back(16'h0020 + 16'(i % 3));
      data_q.push_back(data_of(16'h0020 + 16'(i % 3)));
    end
    kick(16'h0020, 3, 1'b0);
    for (int c = 0; c < 100 && (issue_cnt - i0) < 7; c++) begin
      @(negedge clk);
      #1;
      if (c == 2) begin
        start     = 1'b1;
        base_addr = 16'h0099;
        length    = 17'd5;
      end
      if (c == 3) start = 1'b0;
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    stop = 1'b1;
    @(posedge clk);
    #1;
    stop = 1'b0;
    finish_xfer("t6", 7);
    check("t6_issues", 64'(issue_cnt - i0), 64'(7));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
